// File: rtl/lif_layer_if.sv
// Step/spike handshake and weight-write bus for lif_layer.
interface lif_layer_if #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned W_SIZE = 4
);
  localparam int unsigned A_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;

  logic              step_valid;
  logic              step_ready;
  logic [N_IN-1:0]   spike_in;
  logic              out_valid;
  logic [N_OUT-1:0]  spike_out;
  logic              w_we;
  logic [A_W-1:0]    w_addr;
  logic [W_SIZE-1:0] w_data;

  modport master (
    output step_valid, spike_in, w_we, w_addr, w_data,
    input  step_ready, out_valid, spike_out
  );

  modport slave (
    input  step_valid, spike_in, w_we, w_addr, w_data,
    output step_ready, out_valid, spike_out
  );
endinterface

// File: rtl/lif_layer.sv
// Time-multiplexed leaky integrate-and-fire layer, one neuron evaluated per cycle.
// Optional membrane-potential debug read port: define LIF_LAYER_VMEM_READ_EN.
module lif_layer #(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned N_OUT      = 3,
  parameter int unsigned V_SIZE     = 8,
  parameter int unsigned W_SIZE     = 4,
  parameter int unsigned THRESH     = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 0,
  localparam int unsigned K_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  lif_layer_if.slave        bus
`ifdef LIF_LAYER_VMEM_READ_EN
  ,
  input  logic [K_W-1:0]    dbg_addr,
  output logic [V_SIZE-1:0] dbg_v
`endif
);

  localparam int unsigned NW  = N_IN * N_OUT;
  localparam int unsigned A_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned S_W = V_SIZE + $clog2(N_IN + 1);
  localparam int unsigned R_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [V_SIZE-1:0] V_MAX = '1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [N_IN-1:0]   spk_in_q, spk_in_d;
  logic [N_OUT-1:0]  spk_q, spk_d;
  logic [V_SIZE-1:0] v_q [N_OUT];
  logic [V_SIZE-1:0] v_d [N_OUT];
  logic [R_W-1:0]    refr_q [N_OUT];
  logic [R_W-1:0]    refr_d [N_OUT];
  logic [W_SIZE-1:0] w_q [NW];
  logic [W_SIZE-1:0] w_d [NW];
  logic              step_ready_q, step_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [N_OUT-1:0]  spike_out_q, spike_out_d;

  logic [S_W-1:0]    wsum;
  logic [S_W-1:0]    s;
  logic [V_SIZE-1:0] vl;
  logic [V_SIZE-1:0] sat;

  assign bus.step_ready = step_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.spike_out  = spike_out_q;

  // Next-state, neuron datapath for index k_q, and weight-file writes.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    spk_in_d     = spk_in_q;
    spk_d        = spk_q;
    v_d          = v_q;
    refr_d       = refr_q;
    w_d          = w_q;
    step_ready_d = step_ready_q;
    out_valid_d  = 1'b0;
    spike_out_d  = spike_out_q;

    wsum = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (spk_in_q[i]) begin
        wsum = wsum + S_W'(w_q[A_W'(32'(k_q) * N_IN + i)]);
      end
    end
    vl  = v_q[k_q] - (v_q[k_q] >> LEAK_SHIFT);
    s   = S_W'(vl) + wsum;
    sat = (s > S_W'(V_MAX)) ? V_MAX : V_SIZE'(s);

    unique case (state_q)
      IDLE: begin
        if (bus.step_valid && step_ready_q) begin
          spk_in_d     = bus.spike_in;
          k_d          = '0;
          spk_d        = '0;
          step_ready_d = 1'b0;
          state_d      = EVAL;
        end
      end
      EVAL: begin
        if (refr_q[k_q] != '0) begin
          refr_d[k_q] = refr_q[k_q] - R_W'(1);
          v_d[k_q]    = '0;
          spk_d[k_q]  = 1'b0;
        end else if (sat >= V_SIZE'(THRESH)) begin
          spk_d[k_q]  = 1'b1;
          v_d[k_q]    = '0;
          refr_d[k_q] = R_W'(REFRAC);
        end else begin
          spk_d[k_q]  = 1'b0;
          v_d[k_q]    = sat;
        end
        if (k_q == K_W'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        out_valid_d  = 1'b1;
        spike_out_d  = spk_q;
        step_ready_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Evaluation above reads w_q, so a same-cycle write lands next cycle.
    if (bus.w_we && (32'(bus.w_addr) < NW)) begin
      w_d[bus.w_addr] = bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      spk_in_q     <= '0;
      spk_q        <= '0;
      step_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      spike_out_q  <= '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NW; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      spk_in_q     <= spk_in_d;
      spk_q        <= spk_d;
      step_ready_q <= step_ready_d;
      out_valid_q  <= out_valid_d;
      spike_out_q  <= spike_out_d;
      v_q          <= v_d;
      refr_q       <= refr_d;
      w_q          <= w_d;
    end
  end

`ifdef LIF_LAYER_VMEM_READ_EN
  logic [V_SIZE-1:0] dbg_v_q, dbg_v_d;

  always_comb begin
    dbg_v_d = '0;
    if (32'(dbg_addr) < N_OUT) begin
      dbg_v_d = v_q[dbg_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_v_q <= '0;
    end else begin
      dbg_v_q <= dbg_v_d;
    end
  end

  assign dbg_v = dbg_v_q;
`endif

endmodule
